stack_mem_arbiter: RTL
======================

Name: stack_mem_arbiter

Overview:
- Shares the single-port 256 x 32-bit stack memory between two requesters: port 0 (CPU load/store stage) and port 1 (program loader / debug port).
- Each port uses a valid/ready request channel and a response channel with fixed 1-cycle latency.
- Arbitration is round-robin. A lock lets one port keep the memory for an uninterrupted multi-access sequence, such as a read-modify-write.
- Out-of-range addresses complete with an error response and leave the memory unchanged.

Parameters:
- DW, 32, data width in bits.
- AW, 8, address width in bits (word-addressed).
- DEPTH, 256, number of implemented words; an address is valid when addr < DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per port: request present.
- req_ready  out  2  per port: request accepted this cycle when req_valid is also high.
- req_we  in  2  per port: 1 = write, 0 = read.
- req_lock  in  2  per port: keep the grant after this request.
- req_addr  in  2*AW  per-port word address; port p uses bits [p*AW +: AW].
- req_wdata  in  2*DW  per-port write data.
- resp_valid  out  2  per port: response valid.
- resp_err  out  2  per port: the accepted request was out of range.
- resp_rdata  out  2*DW  per-port read data; zero for writes and errors.
- locked_by  out  2  one-hot owner of the current lock; 00 when unlocked.

Behaviour:
- Reset values:
  - req_ready = 00, resp_valid = 00, resp_err = 00, resp_rdata = 0, locked_by = 00.
  - FSM in IDLE; round-robin pointer = port 0.
  - Memory contents are not reset. Simulation initialises them to 0.
- FSM states:
  - IDLE: no lock held.
  - LOCK0: port 0 owns the memory.
  - LOCK1: port 1 owns the memory.
- Grant in IDLE:
  - If only one port is valid, grant it.
  - If both are valid, grant the port named by the round-robin pointer.
  - After any grant in IDLE, the pointer moves to the other port.
  - req_ready is combinational and one-hot to the granted port. It never goes high for a port whose req_valid is low.
- Grant in LOCKp:
  - Only port p can be granted; the other port's req_ready stays 0.
  - The round-robin pointer does not change.
- Lock transitions, evaluated on an accepted transfer from port p:
  - req_lock = 1: next state is LOCKp.
  - req_lock = 0 while in LOCKp: next state is IDLE.
  - Lock ownership is never taken away by the other port.
- Access and response timing:
  - A request accepted in cycle N reads or writes the memory at the cycle-N edge.
  - resp_valid[p] is high in cycle N+1 for exactly one cycle, for both reads and writes.
  - Throughput is one accepted request per cycle, so back-to-back requests (including across ports) are allowed.
- Out-of-range requests (addr >= DEPTH):
  - No memory write takes place.
  - The response has resp_err = 1 and resp_rdata = 0.
  - Lock state and the pointer update as for a normal request.
- Read-after-write: a read accepted in cycle N+1 to the address written in cycle N returns the new data.
- Responses need no response-ready; the requester must sample them.
- Reset mid-operation:
  - Any pending response is dropped.
  - The lock is released and the FSM returns to IDLE.
  - Memory writes already committed are kept.
- locked_by is registered and equals the one-hot of the current state: LOCK0 gives 01, LOCK1 gives 10.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the state enum (IDLE, LOCK0, LOCK1);
  - port-index constants PORT_CPU = 0 and PORT_LDR = 1;
  - STACK_DEPTH = 256 and the DW/AW defaults.
- Natural sub-module: stack_ram.
  - Synchronous single-port RAM with DEPTH x DW storage.
  - Single-port access: we, addr, wdata, rdata.
  - Read data is registered, giving 1-cycle latency.
- The arbiter FSM, the pointer and the response steering live in stack_mem_arbiter.

Test Plan:
- Port 0 writes 0xDEADBEEF to address 0x10 in cycle 1 and reads 0x10 in cycle 2. Required: write response in cycle 2 with err = 0; read response in cycle 3 with rdata = 0xDEADBEEF.
- Both ports hold req_valid high for 4 cycles after reset. Required: grants go 0, 1, 0, 1, and each response appears on the matching port one cycle after its grant.
- Port 1 reads address 0x20 with req_lock = 1, then writes 0x20 with lock = 0, while port 0 requests continuously. Required: port 0 req_ready = 0 until the port 1 unlocking write is accepted; locked_by = 10 during the lock; port 0 is granted on the next cycle.
- DEPTH = 200 and port 0 writes address 0xF0. Required: resp_err = 1 and rdata = 0; a later read of 0xF0 also returns err = 1; memory at 0x00..0xC7 is unchanged.
- Port 0 takes the lock, then rst is asserted for one cycle. Required: all outputs are zero in the following cycle and the FSM is in IDLE. A port 1 request straight after reset is granted, and the previously written data at address 0x10 still reads back.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants and state encoding for the stack memory arbiter.
// Port indices name the two requesters sharing the stack RAM.
package mips_mem_pkg;
  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 8;
  localparam int STACK_DEPTH = 256;
  localparam int PORT_CPU    = 0;
  localparam int PORT_LDR    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM, DEPTH x DW, registered read data (1-cycle latency).
// Caller guarantees addr < DEPTH whenever en is high.
module stack_ram #(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/stack_mem_arbiter.sv
// Round-robin arbiter with lock sharing one stack RAM between CPU and loader ports.
// One request accepted per cycle; response one cycle later, no response backpressure.
module stack_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [1:0]      req_lock,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      resp_valid,
  output logic [1:0]      resp_err,
  output logic [2*DW-1:0] resp_rdata,
  output logic [1:0]      locked_by
);
  arb_state_e    state_q, state_d;
  logic          rr_q, rr_d;
  logic [1:0]    gnt;
  logic          sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          in_range;
  logic          ram_en, ram_we;
  logic [DW-1:0] ram_rdata;
  logic [1:0]    rvld_q, locked_q;
  logic          rerr_q, rwr_q;

  always_comb begin
    gnt     = '0;
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE:    gnt = (req_valid == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : req_valid;
      LOCK0:   gnt = {1'b0, req_valid[PORT_CPU]};
      LOCK1:   gnt = {req_valid[PORT_LDR], 1'b0};
      default: gnt = '0;
    endcase
    if (rst) gnt = '0;

    sel = gnt[PORT_LDR];
    if (|gnt) begin
      if (state_q == IDLE) rr_d = gnt[PORT_CPU];
      // The other port can never reach here while a lock is held, so release is owner-only.
      if (req_lock[sel])          state_d = sel ? LOCK1 : LOCK0;
      else if (state_q != IDLE)   state_d = IDLE;
    end
  end

  assign addr_sel  = req_addr[sel*AW +: AW];
  assign wdata_sel = req_wdata[sel*DW +: DW];
  assign in_range  = (32'(addr_sel) < DEPTH);
  assign ram_en    = (|gnt) && in_range;
  assign ram_we    = ram_en && req_we[sel];
  assign req_ready = gnt;

  stack_ram #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_sel),
    .wdata (wdata_sel),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      rvld_q   <= '0;
      rerr_q   <= 1'b0;
      rwr_q    <= 1'b0;
      locked_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      rvld_q   <= gnt;
      rerr_q   <= (|gnt) && !in_range;
      rwr_q    <= (|gnt) && req_we[sel];
      locked_q <= {state_d == LOCK1, state_d == LOCK0};
    end
  end

  always_comb begin
    resp_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (rvld_q[p] && !rerr_q && !rwr_q) resp_rdata[p*DW +: DW] = ram_rdata;
    end
  end

  assign resp_valid = rvld_q;
  assign resp_err   = rvld_q & {2{rerr_q}};
  assign locked_by  = locked_q;
endmodule
